scope_capture: RTL and testbench

SCOPE_CAPTURE -- requirements
Module: scope_capture

---
 rtl/scope_pkg.sv | 16 +
 rtl/scope_ram.sv | 44 ++++
 rtl/scope_capture.sv | 160 ++++++++++++++++
 tb/tb_scope_capture.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
// Shared definitions for the scope capture block: capture FSM states,
// default sample width / depth, and the display column address width.
package scope_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 640;
  localparam int COL_W      = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/scope_ram.sv
// Sample buffer for the scope: DEPTH x DATA_W, one write port and one
// registered read port. A read of a column beyond DEPTH returns zero.
module scope_ram
  import scope_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [COL_W-1:0]  wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [COL_W-1:0]  rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Write port.
  // NOTE: the storage array has no reset so it can map onto block RAM;
  // only the read output register below is reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Registered read; a same-cycle write to the same address is not yet
  // visible, so the old contents are returned (read-first).
  // NOTE: non-blocking assignments in clocked blocks are what give every
  // register its pre-edge value here and throughout the design.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else if (32'(rd_addr_i) < DEPTH) begin
      rd_data_q <= mem_q[rd_addr_i];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/scope_capture.sv
// Single-shot oscilloscope capture: waits for a level-crossing trigger on a
// qualified sample stream, then records DEPTH consecutive samples for
// column-by-column display readout.
// Optional feature: define SCOPE_AUTO_TRIG_EN to force a capture after
// AUTO_TIMEOUT qualified samples arrive in ARMED without a trigger.
module scope_capture
  import scope_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int AUTO_TIMEOUT = 65535
) (
  input  logic              CLK,
  input  logic              RST_BTN,
  input  logic              smp_valid,
  input  logic [DATA_W-1:0] smp_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_rise,
  input  logic              arm,
  input  logic [COL_W-1:0]  rd_x,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              auto_trig
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              prev_vld_q, prev_vld_d;
  logic [COL_W-1:0]  wr_addr_q, wr_addr_d;
  logic              busy_q, done_q;

  logic              edge_hit;
  logic              timeout_hit;
  logic              ram_wr_en;
  logic [COL_W-1:0]  ram_wr_addr;

  // Level-crossing detector against the previous sample; needs a valid prev.
  always_comb begin
    edge_hit = 1'b0;
    if (prev_vld_q) begin
      if (trig_rise) edge_hit = (prev_q < trig_level) && (smp_data >= trig_level);
      else           edge_hit = (prev_q > trig_level) && (smp_data <= trig_level);
    end
  end

`ifdef SCOPE_AUTO_TRIG_EN
  localparam int CNT_W = $clog2(AUTO_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             auto_q;

  // The sample that brings the count to AUTO_TIMEOUT is the forced trigger.
  assign timeout_hit = (cnt_q == CNT_W'(AUTO_TIMEOUT - 1));

  // Count qualified samples while armed; held at zero elsewhere so each
  // entry to ARMED starts from a clean count.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != ARMED)  cnt_d = '0;
    else if (smp_valid)    cnt_d = cnt_q + 1'b1;
  end

  // Counter register and the record of how the last capture started.
  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      cnt_q  <= '0;
      auto_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (state_q == ARMED && smp_valid && (edge_hit || timeout_hit))
        auto_q <= !edge_hit;
    end
  end

  assign auto_trig = auto_q;
`else
  // The timeout parameter has no role when the auto trigger is compiled out.
  logic unused_timeout;
  assign unused_timeout = (AUTO_TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
  assign auto_trig      = 1'b0;
`endif

  // Capture FSM next state, previous-sample tracking and buffer write control.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
    wr_addr_d   = wr_addr_q;
    ram_wr_en   = 1'b0;
    ram_wr_addr = wr_addr_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          state_d    = ARMED;
          prev_vld_d = 1'b0;
        end
      end
      ARMED: begin
        if (smp_valid) begin
          prev_d     = smp_data;
          prev_vld_d = 1'b1;
          if (edge_hit || timeout_hit) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = '0;
            wr_addr_d   = COL_W'(1);
            state_d     = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (smp_valid) begin
          ram_wr_en = 1'b1;
          wr_addr_d = wr_addr_q + 1'b1;
          if (wr_addr_q == COL_W'(DEPTH - 1)) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; busy/done decode the next state so they line up with it.
  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      wr_addr_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      wr_addr_q  <= wr_addr_d;
      busy_q     <= (state_d == ARMED) || (state_d == CAPTURE);
      done_q     <= (state_d == DONE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  scope_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i     (CLK),
    .rst_ni    (RST_BTN),
    .wr_en_i   (ram_wr_en),
    .wr_addr_i (ram_wr_addr),
    .wr_data_i (smp_data),
    .rd_addr_i (rd_x),
    .rd_data_o (rd_data)
  );

endmodule

// File: tb/tb_scope_capture.sv
// Self-checking bench for scope_capture. Stimulus pushes expected read data
// and status words ({busy,done,auto_trig}) into a scoreboard queue; a monitor
// pops and compares when the DUT presents read data or a status sample.
// Covers SCOPE_AUTO_TRIG_EN both defined and undefined.
module tb_scope_capture;

  localparam int DW    = 8;
  localparam int DEPTH = 640;

  logic          CLK = 1'b0;
  logic          RST_BTN;
  logic          smp_valid;
  logic [DW-1:0] smp_data;
  logic [DW-1:0] trig_level;
  logic          trig_rise;
  logic          arm;
  logic [9:0]    rd_x;
  logic [DW-1:0] rd_data;
  logic          busy, done, auto_trig;

  always #5 CLK = ~CLK;

  scope_capture #(.DATA_W(DW), .DEPTH(DEPTH), .AUTO_TIMEOUT(16)) dut (
    .CLK        (CLK),
    .RST_BTN    (RST_BTN),
    .smp_valid  (smp_valid),
    .smp_data   (smp_data),
    .trig_level (trig_level),
    .trig_rise  (trig_rise),
    .arm        (arm),
    .rd_x       (rd_x),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .auto_trig  (auto_trig)
  );

  typedef struct {
    bit          is_rd;
    string       name;
    logic [31:0] exp;
  } item_t;

  item_t sb_q[$];
  int    num_checks = 0;
  int    num_errors = 0;
  logic  rd_req   = 1'b0;
  logic  rd_seen  = 1'b0;
  logic  stat_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_check(input bit is_rd, input logic [31:0] act);
    item_t it;
    if (sb_q.size() == 0) begin
      num_checks++;
      num_errors++;
      $display("FAIL scoreboard_empty: got output with no expectation (read=%0d)", is_rd);
    end else begin
      it = sb_q.pop_front();
      if (it.is_rd != is_rd) begin
        num_checks++;
        num_errors++;
        $display("FAIL %s: scoreboard kind got %0d expected %0d", it.name, is_rd, it.is_rd);
      end else begin
        check(it.name, act, it.exp);
      end
    end
  endtask

  // Read data appears one edge after the read request was sampled.
  always @(posedge CLK) rd_seen <= rd_req;

  // Monitor: compare away from the active edge.
  always @(negedge CLK) begin
    if (rd_seen)  pop_check(1'b1, 32'(rd_data));
    if (stat_req) pop_check(1'b0, {29'b0, busy, done, auto_trig});
  end

  task automatic step();
    @(posedge CLK);
    #1;
    smp_valid = 1'b0;
    arm       = 1'b0;
    rd_req    = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d);
    smp_valid = 1'b1;
    smp_data  = d;
    step();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
  endtask

  task automatic rd_set(input int a, input logic [DW-1:0] e, input string n);
    item_t it;
    it.is_rd = 1'b1;
    it.name  = n;
    it.exp   = 32'(e);
    sb_q.push_back(it);
    rd_x   = 10'(a);
    rd_req = 1'b1;
  endtask

  task automatic rd(input int a, input logic [DW-1:0] e, input string n);
    rd_set(a, e, n);
    step();
  endtask

  task automatic stat(input logic [2:0] e, input string n);
    item_t it;
    it.is_rd = 1'b0;
    it.name  = n;
    it.exp   = 32'(e);
    sb_q.push_back(it);
    stat_req = 1'b1;
    @(negedge CLK);
    #1;
    stat_req = 1'b0;
  endtask

  // Writes 1..n after the trigger sample, value (k+off) mod 256.
  task automatic fill(input int n, input int off);
    for (int k = 1; k <= n; k++) send(DW'(k + off));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_BTN    = 1'b0;
    smp_valid  = 1'b0;
    smp_data   = '0;
    trig_level = 8'd128;
    trig_rise  = 1'b1;
    arm        = 1'b0;
    rd_x       = '0;
    step();
    step();

    // Reset state.
    rd(5, 8'd0, "reset_rd_data");
    stat(3'b000, "reset_status");
    RST_BTN = 1'b1;
    step();
    stat(3'b000, "idle_after_reset");

    // Samples in IDLE are ignored; rising trigger on 130 at level 128.
    send(8'd100);
    send(8'd200);
    do_arm();
    stat(3'b100, "armed_busy");
    send(8'd100);
    send(8'd120);
    send(8'd130);
    stat(3'b100, "capture_busy");
    rd(0, 8'd130, "rise_addr0");
    // 640 writes total: trigger + 639; arm mid-capture has no effect.
    fill(300, 0);
    do_arm();
    for (int k = 301; k <= 638; k++) send(DW'(k));
    stat(3'b100, "not_done_before_last");
    send(DW'(639));
    stat(3'b010, "done_after_640");
    send(8'd200);
    stat(3'b010, "done_hold");
    rd(0,   8'd130, "addr0_kept");
    rd(1,   8'd1,   "addr1");
    rd(320, 8'd64,  "addr320");
    rd(639, 8'd127, "addr639");
    rd(640, 8'd0,   "oob_640");
    rd(700, 8'd0,   "oob_700");
    rd(638, 8'd126, "addr638");

    // Falling trigger on 50 at level 50; first sample 40 must not trigger.
    trig_rise  = 1'b0;
    trig_level = 8'd50;
    do_arm();
    stat(3'b100, "rearmed");
    send(8'd40);
    send(8'd60);
    send(8'd50);
    rd_set(1, 8'd1, "read_first");
    send(8'd4);
    for (int k = 2; k <= 638; k++) send(DW'(k + 3));
    stat(3'b100, "fall_not_done");
    send(DW'(639 + 3));
    stat(3'b010, "fall_done");
    rd(0,   8'd50,  "fall_addr0");
    rd(1,   8'd4,   "fall_addr1");
    rd(639, 8'd130, "fall_addr639");

    // Reset during capture after 300 writes; re-arm needs a fresh trigger.
    trig_rise  = 1'b1;
    trig_level = 8'd128;
    do_arm();
    send(8'd100);
    send(8'd128);
    fill(299, 10);
    RST_BTN = 1'b0;
    stat(3'b000, "reset_mid_capture");
    step();
    RST_BTN = 1'b1;
    step();
    stat(3'b000, "idle_after_abort");
    send(8'd100);
    send(8'd200);
    do_arm();
    for (int k = 0; k < 5; k++) send(8'd200);
    send(8'd100);
    send(8'd150);
    fill(638, 20);
    stat(3'b100, "abort_not_done");
    send(DW'(639 + 20));
    stat(3'b010, "abort_done");
    rd(0,   8'd150, "abort_addr0");
    rd(300, 8'd64,  "abort_addr300");
    rd(639, 8'd147, "abort_addr639");

    // Constant input below level: auto trigger or wait forever.
    do_arm();
`ifdef SCOPE_AUTO_TRIG_EN
    for (int k = 0; k < 15; k++) send(8'd90);
    stat(3'b100, "auto_pending");
    send(8'd90);
    stat(3'b101, "auto_fired");
    fill(638, 0);
    stat(3'b101, "auto_not_done");
    send(DW'(639));
    stat(3'b011, "auto_done");
    rd(0, 8'd90, "auto_addr0");
    do_arm();
    send(8'd100);
    send(8'd130);
    stat(3'b100, "auto_cleared");
`else
    for (int k = 0; k < 40; k++) send(8'd90);
    stat(3'b100, "no_auto_armed");
    send(8'd200);
    fill(638, 0);
    stat(3'b100, "manual_not_done");
    send(DW'(639));
    stat(3'b010, "manual_done");
    rd(0, 8'd200, "manual_addr0");
`endif

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
    if (sb_q.size() != 0) begin
      num_checks++;
      num_errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
